pool_rd_stream: RTL

POOL_RD_STREAM -- requirements
Module: pool_rd_stream

---
 rtl/pool_rd_stream.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pool_rd_stream.sv
// pool_rd_stream: reads one frame of layer-1 words from memory and streams
// them out through a 2-entry FIFO with valid/ready handshake, accumulating
// sum, maximum value and the address of the first maximum on accepted words.
module pool_rd_stream #(
    parameter int N_WORDS = 1024,
    parameter int DW      = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          csel,
    output logic          crd,
    output logic [11:0]   caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          done,
    output logic [DW-1:0] max_val,
    output logic [9:0]    max_idx,
    output logic [DW+9:0] sum
);

    localparam logic [9:0] LAST_ADDR = 10'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [9:0]    ptr;
    logic [DW-1:0] fifo_data [2];
    logic [9:0]    fifo_tag  [2];
    logic          wr_sel;
    logic          rd_sel;
    logic [1:0]    fifo_cnt;
    logic          push;
    logic          pop;
    logic          head_last;
    logic          frame_go;

    // A start is only honoured from IDLE; pulses in any other state are dropped.
    assign frame_go  = (state == IDLE) && start;

    // Stream side: the FIFO head is presented whenever anything is buffered.
    // Data and last are forced to zero while empty so no stale word is visible.
    assign o_valid   = (fifo_cnt != 2'd0);
    assign pop       = o_valid && o_ready;
    assign head_last = o_valid && (fifo_tag[rd_sel] == LAST_ADDR);
    assign o_data    = o_valid ? fifo_data[rd_sel] : '0;
    assign o_last    = head_last;

    // Every issued read lands in the FIFO at the following edge.
    assign push      = crd;

    // Next-state and control outputs; reads are throttled so the FIFO never overflows.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        csel      = 1'b1;
        crd       = 1'b0;
        caddr_rd  = '0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                csel = 1'b0;
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                caddr_rd = {2'b00, ptr};
                // A read is safe when a slot is free now or is freed by this cycle's pop.
                crd      = (fifo_cnt != 2'd2) || pop;
                if (crd && (ptr == LAST_ADDR)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read pointer: restarts at each accepted start and parks on the last address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (frame_go) begin
            ptr <= '0;
        end else if (push && (ptr != LAST_ADDR)) begin
            ptr <= ptr + 10'd1;
        end
    end

    // FIFO occupancy and slot pointers; push and pop in the same cycle keep the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_cnt <= 2'd0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            if (push) begin
                wr_sel <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage: each word is tagged with the address it was read from.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_sel] <= cdata_rd;
            fifo_tag[wr_sel]  <= ptr;
        end
    end

    // Frame statistics over accepted words; strict compare keeps the earliest maximum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_val <= '0;
            max_idx <= '0;
            sum     <= '0;
        end else if (frame_go) begin
            max_val <= '0;
            max_idx <= '0;
            sum     <= '0;
        end else if (pop) begin
            sum <= sum + {10'b0, o_data};
            if (o_data > max_val) begin
                max_val <= o_data;
                max_idx <= fifo_tag[rd_sel];
            end
        end
    end

endmodule
